// File: rtl/bdc_pkg.sv
// Shared definitions for the barrel distortion correction pipeline:
// conformer state encoding and default geometry.
package bdc_pkg;

  // States of the input frame conformer
  typedef enum logic [2:0] {
    ST_WAIT_SOF,
    ST_ACTIVE,
    ST_PAD_LINE,
    ST_DISCARD,
    ST_PAD_FRAME
  } bdc_state_e;

  localparam int BDC_WIDTH       = 1920;
  localparam int BDC_HEIGHT      = 1080;
  localparam int BDC_DATA_WIDTH  = 24;
  localparam int BDC_COORD_WIDTH = 16;

endpackage

// File: rtl/axis_out_reg.sv
// One-deep AXI4-Stream output register with advance logic.
// Holds a beat stable while the sink stalls.
module axis_out_reg #(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic          user_i,
  input  logic          tready_i,
  output logic [DW-1:0] tdata_o,
  output logic          tvalid_o,
  output logic          tlast_o,
  output logic          tuser_o,
  output logic          adv_o
);

  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          last_q;
  logic          user_q;

  assign adv_o    = !valid_q || tready_i;
  assign tdata_o  = data_q;
  assign tvalid_o = valid_q;
  assign tlast_o  = last_q;
  assign tuser_o  = user_q;

  // Take a new beat whenever the slot is empty or being drained
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
    end else if (adv_o) begin
      valid_q <= load_i;
      if (load_i) begin
        data_q <= data_i;
        last_q <= last_i;
        user_q <= user_i;
      end
    end
  end

endmodule

// File: rtl/axis_frame_conformer.sv
// Forces a raw video stream into fixed WIDTH x HEIGHT frames:
// pads short lines/frames, drops excess and pre-SOF beats.
module axis_frame_conformer
  import bdc_pkg::*;
#(
  parameter int                    WIDTH       = BDC_WIDTH,
  parameter int                    HEIGHT      = BDC_HEIGHT,
  parameter int                    DATA_WIDTH  = BDC_DATA_WIDTH,
  parameter int                    COORD_WIDTH = BDC_COORD_WIDTH,
  parameter logic [DATA_WIDTH-1:0] PAD_PIXEL   = '0,
  parameter bit                    EOF_TLAST   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_early_sof,
  output logic                  frame_done
);

  localparam logic [COORD_WIDTH-1:0] XMAX = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] YMAX = COORD_WIDTH'(HEIGHT - 1);

  bdc_state_e             state_q;
  logic [COORD_WIDTH-1:0] x_q;
  logic [COORD_WIDTH-1:0] y_q;
  logic                   eof_q;
  logic                   err_short_q;
  logic                   err_long_q;
  logic                   err_sof_q;

  logic                   adv;
  logic                   emit;
  logic [DATA_WIDTH-1:0]  emit_data;
  logic                   emit_user;
  logic                   rdy;
  logic                   at_eol;
  logic                   at_eof;
  logic                   sof_in;

  assign at_eol = (x_q == XMAX);
  assign at_eof = at_eol && (y_q == YMAX);
  assign sof_in = s_axis_tvalid && s_axis_tuser;

  assign s_axis_tready = rdy && !rst;
  assign err_short     = err_short_q;
  assign err_long      = err_long_q;
  assign err_early_sof = err_sof_q;
  assign frame_done    = m_axis_tvalid && m_axis_tready && eof_q;

  // Per-state input acceptance and output beat selection
  always_comb begin
    rdy       = 1'b0;
    emit      = 1'b0;
    emit_data = PAD_PIXEL;
    emit_user = 1'b0;
    unique case (state_q)
      ST_WAIT_SOF: begin
        rdy       = adv || !s_axis_tuser;
        emit      = sof_in && adv;
        emit_data = s_axis_tdata;
        emit_user = 1'b1;
      end
      ST_ACTIVE: begin
        rdy       = adv && !s_axis_tuser;
        emit      = s_axis_tvalid && !s_axis_tuser && adv;
        emit_data = s_axis_tdata;
      end
      ST_PAD_LINE,
      ST_PAD_FRAME: begin
        emit = adv;
      end
      ST_DISCARD: begin
        rdy = !s_axis_tuser;
      end
      default: begin
        rdy = 1'b0;
      end
    endcase
  end

  axis_out_reg #(
    .DW (DATA_WIDTH)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .load_i   (emit),
    .data_i   (emit_data),
    .last_i   (EOF_TLAST ? at_eof : at_eol),
    .user_i   (emit_user),
    .tready_i (m_axis_tready),
    .tdata_o  (m_axis_tdata),
    .tvalid_o (m_axis_tvalid),
    .tlast_o  (m_axis_tlast),
    .tuser_o  (m_axis_tuser),
    .adv_o    (adv)
  );

  // Frame position tracking, state transitions and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT_SOF;
      x_q         <= '0;
      y_q         <= '0;
      eof_q       <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_sof_q   <= 1'b0;
    end else begin
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_sof_q   <= 1'b0;
      if (adv) eof_q <= emit && at_eof;
      if (emit) begin
        if (at_eol) begin
          x_q <= '0;
          y_q <= at_eof ? '0 : y_q + COORD_WIDTH'(1);
        end else begin
          x_q <= x_q + COORD_WIDTH'(1);
        end
      end
      unique case (state_q)
        ST_WAIT_SOF: begin
          if (emit) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (sof_in) begin
            err_sof_q <= 1'b1;
            state_q   <= ST_PAD_FRAME;
          end else if (emit) begin
            if (s_axis_tlast && !at_eol) begin
              err_short_q <= 1'b1;
              state_q     <= ST_PAD_LINE;
            end else if (at_eol) begin
              err_long_q <= !s_axis_tlast;
              if (at_eof) state_q <= ST_WAIT_SOF;
              else if (!s_axis_tlast) state_q <= ST_DISCARD;
            end
          end
        end
        ST_PAD_LINE: begin
          if (emit && at_eol)
            state_q <= at_eof ? ST_WAIT_SOF : ST_ACTIVE;
        end
        ST_DISCARD: begin
          if (sof_in) begin
            err_sof_q <= 1'b1;
            state_q   <= ST_PAD_FRAME;
          end else if (s_axis_tvalid && s_axis_tlast) begin
            state_q <= ST_ACTIVE;
          end
        end
        ST_PAD_FRAME: begin
          if (emit && at_eof) state_q <= ST_WAIT_SOF;
        end
        default: state_q <= ST_WAIT_SOF;
      endcase
    end
  end

endmodule
